// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind the 16x-oversampled UART receiver: sync hunt, length/payload/checksum, buffered release.
// Optional build macro UART_RX_PKT_STATS_EN adds saturating good/error packet counters.

// state   | meaning
// IDLE    | hunting for SYNC_BYTE
// LEN     | waiting for the length byte
// PAYLOAD | collecting len payload bytes into the buffer
// CHK     | waiting for the checksum byte
// SEND    | streaming the validated payload to the sink
module uart_rx_pkt_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          MAX_LEN   = 16,
  parameter logic [15:0] TIMEOUT   = 16'd2000,
  parameter int          FERR_DLY  = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_perr,
  input  logic        rx_ferr,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        pkt_done,
  output logic [7:0]  pkt_len,
  output logic        pkt_err,
  output logic [2:0]  err_code,
  output logic        busy,
`ifdef UART_RX_PKT_STATS_EN
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt,
`endif
  output logic        ovr_drop
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int FW = $clog2(FERR_DLY + 1);

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_PAR  = 3'd1;
  localparam logic [2:0] E_FRM  = 3'd2;
  localparam logic [2:0] E_LEN  = 3'd3;
  localparam logic [2:0] E_CHK  = 3'd4;
  localparam logic [2:0] E_TMO  = 3'd5;

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, SEND} state_t;

  state_t        state;
  logic [7:0]    len;
  logic [7:0]    idx;
  logic [7:0]    rd_idx;
  logic [7:0]    chk;
  logic [FW-1:0] ferr_cnt;
  logic [15:0]   to_cnt;
  logic [7:0]    pbuf [MAX_LEN];

  logic          rx_phase;
  logic          ferr_due;
  logic          len_ok;
  logic [7:0]    chk_sum;
  logic [7:0]    rd_nxt;
  logic [2:0]    abort_code;

  assign rx_phase = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  // ferr_cnt reaches 1 exactly FERR_DLY edges after the arming byte; 0 means disarmed
  assign ferr_due = (ferr_cnt == FW'(1));
  assign len_ok   = (rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN));
  assign chk_sum  = chk + rx_data;
  assign rd_nxt   = rd_idx + 8'd1;
  assign busy     = (state != IDLE);

  // Frame error outranks a coincident byte; a coincident byte outranks the timeout.
  always_comb begin
    abort_code = E_NONE;
    if ((rx_phase || state == SEND) && ferr_due && rx_ferr) begin
      abort_code = E_FRM;
    end else if (rx_phase) begin
      if (rx_valid) begin
        if (rx_perr)
          abort_code = E_PAR;
        else if (state == LEN && !len_ok)
          abort_code = E_LEN;
        else if (state == CHK && chk_sum != 8'd0)
          abort_code = E_CHK;
      end else if (to_cnt == 16'd0) begin
        abort_code = E_TMO;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= 8'd0;
      idx       <= 8'd0;
      rd_idx    <= 8'd0;
      chk       <= 8'd0;
      ferr_cnt  <= '0;
      to_cnt    <= 16'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_len   <= 8'd0;
      pkt_err   <= 1'b0;
      err_code  <= 3'd0;
      ovr_drop  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      ovr_drop <= (state == SEND) && rx_valid;
      if (ferr_cnt != '0)
        ferr_cnt <= ferr_cnt - FW'(1);
      if (rx_phase && to_cnt != 16'd0)
        to_cnt <= to_cnt - 16'd1;

      if (abort_code != E_NONE) begin
        state     <= IDLE;
        pkt_err   <= 1'b1;
        err_code  <= abort_code;
        out_valid <= 1'b0;
        ferr_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE && !rx_perr) begin
              state    <= LEN;
              ferr_cnt <= FW'(FERR_DLY);
              to_cnt   <= TIMEOUT - 16'd1;
            end
          end
          LEN: begin
            if (rx_valid) begin
              ferr_cnt <= FW'(FERR_DLY);
              to_cnt   <= TIMEOUT - 16'd1;
              len      <= rx_data;
              chk      <= rx_data;
              idx      <= 8'd0;
              state    <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (rx_valid) begin
              ferr_cnt <= FW'(FERR_DLY);
              to_cnt   <= TIMEOUT - 16'd1;
              chk      <= chk_sum;
              idx      <= idx + 8'd1;
              if (idx == len - 8'd1)
                state <= CHK;
            end
          end
          CHK: begin
            // Re-arm so a frame error on the checksum byte can still retract SEND.
            if (rx_valid) begin
              ferr_cnt  <= FW'(FERR_DLY);
              to_cnt    <= TIMEOUT - 16'd1;
              state     <= SEND;
              pkt_done  <= 1'b1;
              pkt_len   <= len;
              err_code  <= E_NONE;
              out_valid <= 1'b1;
              out_data  <= pbuf[0];
              rd_idx    <= 8'd0;
            end
          end
          SEND: begin
            if (out_valid && out_ready) begin
              if (rd_idx == len - 8'd1) begin
                state     <= IDLE;
                out_valid <= 1'b0;
              end else begin
                rd_idx   <= rd_nxt;
                out_data <= pbuf[rd_nxt[AW-1:0]];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == PAYLOAD && rx_valid && abort_code == E_NONE)
      pbuf[idx[AW-1:0]] <= rx_data;
  end

`ifdef UART_RX_PKT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= 16'd0;
      err_cnt  <= 16'd0;
    end else begin
      if (pkt_done && good_cnt != 16'hFFFF)
        good_cnt <= good_cnt + 16'd1;
      if (pkt_err && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed self-checking bench for uart_rx_pkt_ctrl (default parameters).
module tb_uart_rx_pkt_ctrl;

  localparam int TIMEOUT  = 2000;
  localparam int FERR_DLY = 17;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_perr = 1'b0;
  logic       rx_ferr = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       pkt_done;
  logic [7:0] pkt_len;
  logic       pkt_err;
  logic [2:0] err_code;
  logic       busy;
  logic       ovr_drop;
`ifdef UART_RX_PKT_STATS_EN
  logic [15:0] good_cnt;
  logic [15:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  uart_rx_pkt_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_perr  (rx_perr),
    .rx_ferr  (rx_ferr),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pkt_done (pkt_done),
    .pkt_len  (pkt_len),
    .pkt_err  (pkt_err),
    .err_code (err_code),
    .busy     (busy),
`ifdef UART_RX_PKT_STATS_EN
    .good_cnt (good_cnt),
    .err_cnt  (err_cnt),
`endif
    .ovr_drop (ovr_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic perr);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_perr  = perr;
    tick();
    rx_valid = 1'b0;
    rx_perr  = 1'b0;
    rx_data  = 8'd0;
  endtask

  // Good packet: 03+11+22+33 = 69, so checksum byte is 97.
  task automatic send_good_pkt();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h97, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++;
    if ({out_valid, pkt_done, pkt_err, busy, ovr_drop, err_code, pkt_len, out_data} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%b e=%b b=%b o=%b c=%0d l=%h q=%h want all 0",
               out_valid, pkt_done, pkt_err, busy, ovr_drop, err_code, pkt_len, out_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_good();
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    out_ready = 1'b1;
    send_good_pkt();
    checks++;
    if (pkt_done !== 1'b1 || pkt_len !== 8'd3 || err_code !== 3'd0) begin
      errors++;
      $display("FAIL good_done: got done=%b len=%0d code=%0d want 1 3 0", pkt_done, pkt_len, err_code);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        errors++;
        $display("FAIL good_stream[%0d]: got v=%b d=%h want 1 %h", i, out_valid, out_data, exp[i]);
      end
      if (i == 1) begin
        checks++;
        if (pkt_done !== 1'b0) begin
          errors++;
          $display("FAIL good_done_pulse: got %b want 0", pkt_done);
        end
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL good_end: got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_bad_chk();
    out_ready = 1'b1;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h98, 1'b0);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd4 || out_valid !== 1'b0 || busy !== 1'b0 || pkt_done !== 1'b0) begin
      errors++;
      $display("FAIL bad_chk: got err=%b code=%0d v=%b busy=%b done=%b want 1 4 0 0 0",
               pkt_err, err_code, out_valid, busy, pkt_done);
    end
    tick();
    checks++;
    if (pkt_err !== 1'b0 || err_code !== 3'd4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_chk_hold: got err=%b code=%0d v=%b want 0 4 0", pkt_err, err_code, out_valid);
    end
  endtask

  task automatic test_bad_len();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len_zero: got err=%b code=%0d busy=%b want 1 3 0", pkt_err, err_code, busy);
    end
    idle(2);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b0);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len_over: got err=%b code=%0d busy=%b want 1 3 0", pkt_err, err_code, busy);
    end
    idle(2);
    // MAX_LEN packet, payload 01..10: 10 + 88 = 98, checksum 68.
    out_ready = 1'b1;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b0);
    send_byte(8'h68, 1'b0);
    checks++;
    if (pkt_done !== 1'b1 || pkt_len !== 8'd16 || err_code !== 3'd0) begin
      errors++;
      $display("FAIL len_max_done: got done=%b len=%0d code=%0d want 1 16 0", pkt_done, pkt_len, err_code);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i + 1)) begin
        errors++;
        $display("FAIL len_max_stream[%0d]: got v=%b d=%h want 1 %h", i, out_valid, out_data, 8'(i + 1));
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL len_max_end: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_parity();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b0);
    checks++;
    if (busy !== 1'b0 || pkt_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: got busy=%b err=%b want 0 0", busy, pkt_err);
    end
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL parity: got err=%b code=%0d busy=%b want 1 1 0", pkt_err, err_code, busy);
    end
    idle(2);
  endtask

  task automatic test_frame();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    idle(FERR_DLY - 1);
    checks++;
    if (busy !== 1'b1 || pkt_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_pre: got busy=%b err=%b want 1 0", busy, pkt_err);
    end
    rx_ferr = 1'b1;
    tick();
    rx_ferr = 1'b0;
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame: got err=%b code=%0d busy=%b want 1 2 0", pkt_err, err_code, busy);
    end
    idle(2);
  endtask

  task automatic test_frame_send();
    out_ready = 1'b0;
    send_good_pkt();
    idle(FERR_DLY - 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL frame_send_pre: got v=%b d=%h want 1 11", out_valid, out_data);
    end
    rx_ferr = 1'b1;
    tick();
    rx_ferr = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || pkt_err !== 1'b1 || err_code !== 3'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_send: got v=%b err=%b code=%0d busy=%b want 0 1 2 0",
               out_valid, pkt_err, err_code, busy);
    end
    idle(2);
  endtask

  task automatic test_timeout();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    idle(TIMEOUT - 1);
    checks++;
    if (pkt_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got err=%b busy=%b want 0 1", pkt_err, busy);
    end
    tick();
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got err=%b code=%0d busy=%b want 1 5 0", pkt_err, err_code, busy);
    end
    idle(2);
    out_ready = 1'b1;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    idle(TIMEOUT - 2);
    send_byte(8'h11, 1'b0);
    checks++;
    if (pkt_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_alive_m1: got err=%b busy=%b want 0 1", pkt_err, busy);
    end
    idle(TIMEOUT - 1);
    send_byte(8'h22, 1'b0);
    checks++;
    if (pkt_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_alive_eq: got err=%b busy=%b want 0 1", pkt_err, busy);
    end
    send_byte(8'h33, 1'b0);
    send_byte(8'h97, 1'b0);
    checks++;
    if (pkt_done !== 1'b1 || pkt_len !== 8'd3) begin
      errors++;
      $display("FAIL timeout_alive_done: got done=%b len=%0d want 1 3", pkt_done, pkt_len);
    end
    idle(3);
  endtask

  task automatic test_overrun();
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    out_ready = 1'b0;
    send_good_pkt();
    idle(10);
    send_byte(8'hA5, 1'b0);
    checks++;
    if (ovr_drop !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL ovr_pulse: got ovr=%b busy=%b v=%b d=%h want 1 1 1 11", ovr_drop, busy, out_valid, out_data);
    end
    tick();
    checks++;
    if (ovr_drop !== 1'b0) begin
      errors++;
      $display("FAIL ovr_one_cycle: got %b want 0", ovr_drop);
    end
    idle(38);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        errors++;
        $display("FAIL ovr_stream[%0d]: got v=%b d=%h want 1 %h", i, out_valid, out_data, exp[i]);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || pkt_err !== 1'b0) begin
      errors++;
      $display("FAIL ovr_end: got busy=%b v=%b err=%b want 0 0 0", busy, out_valid, pkt_err);
    end
  endtask

  task automatic test_reset_send();
    out_ready = 1'b0;
    send_good_pkt();
    idle(5);
    rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, pkt_done, pkt_err, busy, ovr_drop, err_code, pkt_len, out_data} !== 24'd0) begin
      errors++;
      $display("FAIL reset_send: got v=%b busy=%b c=%0d l=%h q=%h want all 0",
               out_valid, busy, err_code, pkt_len, out_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good();
    test_bad_chk();
    test_bad_len();
    test_parity();
    test_frame();
    test_frame_send();
    test_timeout();
    test_overrun();
    test_reset_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
